// File: rtl/clm_key_schedule_nk_if.sv
// Round-key request/response bundle between the CLM round datapath and the
// key schedule, including the embedding parameters (L matrix, field poly P).
interface clm_key_schedule_nk_if #(
   parameter int D      = 4,
   parameter int NK     = 4,
   parameter int N_SBOX = 4,
   parameter int R_W    = 8
);
   localparam int BW = 8 + D;

   logic                            start;
   logic [NK-1:0][3:0][BW-1:0]      key_in;
   logic                            req;
   logic [N_SBOX*R_W-1:0]           r;
   logic [7:0][7:0]                 L;
   logic [0:7]                      P;
   logic [3:0][3:0][BW-1:0]         rk_o;
   logic                            rk_vld;
   logic [3:0]                      rnd_o;
   logic                            busy;
   logic                            done;

   modport master (
      output start, key_in, req, r, L, P,
      input  rk_o, rk_vld, rnd_o, busy, done
   );

   modport slave (
      input  start, key_in, req, r, L, P,
      output rk_o, rk_vld, rnd_o, busy, done
   );
endinterface

// File: rtl/clm_key_schedule_nk.sv
// On-demand AES-128/192/256 round-key generator on embedded (masked) bytes.
// Keeps a sliding window of the last NK words and produces one 4-word round
// key per request, sharing N_SBOX S-box lanes over 4/N_SBOX passes.
module clm_key_schedule_nk #(
   parameter int D      = 4,
   parameter int NK     = 4,
   parameter int N_SBOX = 4,
   parameter int R_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   clm_key_schedule_nk_if.slave  bus
);
   localparam int BW = 8 + D;
   localparam int NR = NK + 6;
   localparam int NP = 4 / N_SBOX;

   if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("clm_key_schedule_nk: NK must be 4, 6 or 8");
   end
   if (!(N_SBOX == 1 || N_SBOX == 2 || N_SBOX == 4)) begin : g_bad_nsbox
      $error("clm_key_schedule_nk: N_SBOX must be 1, 2 or 4");
   end

   typedef logic [3:0][BW-1:0] word_t;
   typedef enum logic [2:0] {S_IDLE, S_SEL, S_SUB, S_XOR, S_EMIT} state_t;
   typedef enum logic [1:0] {K_KEY, K_ROT, K_SUB, K_LIN} kind_t;

   // [0:7]-ordered polynomial to a byte with bit k = coefficient of x^k
   function automatic logic [7:0] le_of(input logic [0:7] v);
      logic [7:0] o;
      for (int k = 0; k < 8; k++) o[k] = v[k];
      return o;
   endfunction

   function automatic logic [7:0] input_transform(input logic [7:0] b, input logic [7:0][7:0] m);
      logic [7:0] o;
      for (int i = 0; i < 8; i++) o[i] = ^(m[i] & b);
      return o;
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] red);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ red) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // inverse as x^254 (0 maps to 0), then the AES affine map
   function automatic logic [7:0] sbox_byte(input logic [7:0] x, input logic [7:0] red);
      logic [7:0] a;
      logic [7:0] s;
      a = x;
      for (int k = 0; k < 6; k++) a = gf_mul(gf_mul(a, a, red), x, red);
      a = gf_mul(a, a, red);
      for (int i = 0; i < 8; i++)
         s[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8];
      return s ^ 8'h63;
   endfunction

   // value bits substituted, redundancy bits re-randomised with this lane's r
   function automatic logic [BW-1:0] sbox_emb(input logic [BW-1:0] x, input logic [R_W-1:0] m,
                                              input logic [7:0] red);
      logic [D-1:0] msk;
      msk = '0;
      for (int k = 0; k < R_W; k++) msk[k%D] = msk[k%D] ^ m[k];
      return {sbox_byte(x[BW-1:D], red), x[D-1:0] ^ msk};
   endfunction

   state_t                   state_q, state_d;
   kind_t                    kind_q, kind_d;
   logic [5:0]               wi_q, wi_d;
   logic [2:0]               mod_q, mod_d;
   logic [0:7]               rc_q, rc_d;
   word_t [NK-1:0]           win_q, win_d;
   word_t [3:0]              slot_q, slot_d;
   word_t                    sin_q, sin_d;
   word_t                    sub_q, sub_d;
   logic [1:0]               pass_q, pass_d;
   logic                     iss_q, iss_d;
   logic                     ld_q, ld_d;
   logic [3:0][3:0][BW-1:0]  rk_q, rk_d;
   logic                     vld_q, vld_d;
   logic [3:0]               rnd_q, rnd_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic                         sb_go;
   logic [N_SBOX-1:0][BW-1:0]    sb_in;
   logic [N_SBOX-1:0][BW-1:0]    sbo_q;
   logic [N_SBOX-1:0]            rdy_q;
   logic [7:0]                   red_w;
   word_t                        rcw, nw;
   logic [1:0]                   bi;
   logic [3:0]                   rnd_n;

   assign red_w = le_of(bus.P);

   // S-box lanes: one pass per drdy_i pulse, result and drdy_o one cycle later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbo_q <= '0;
         rdy_q <= '0;
      end else begin
         rdy_q <= {N_SBOX{sb_go}};
         if (sb_go)
            for (int l = 0; l < N_SBOX; l++)
               sbo_q[l] <= sbox_emb(sb_in[l], bus.r[l*R_W +: R_W], red_w);
      end
   end

   // state and schedule registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         kind_q  <= K_KEY;
         wi_q    <= '0;
         mod_q   <= '0;
         rc_q    <= 8'd128;
         win_q   <= '0;
         slot_q  <= '0;
         sin_q   <= '0;
         sub_q   <= '0;
         pass_q  <= '0;
         iss_q   <= 1'b0;
         ld_q    <= 1'b0;
         rk_q    <= '0;
         vld_q   <= 1'b0;
         rnd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         wi_q    <= wi_d;
         mod_q   <= mod_d;
         rc_q    <= rc_d;
         win_q   <= win_d;
         slot_q  <= slot_d;
         sin_q   <= sin_d;
         sub_q   <= sub_d;
         pass_q  <= pass_d;
         iss_q   <= iss_d;
         ld_q    <= ld_d;
         rk_q    <= rk_d;
         vld_q   <= vld_d;
         rnd_q   <= rnd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // next-state: request accept, word classification, S-box passes, window update, emit
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      wi_d    = wi_q;
      mod_d   = mod_q;
      rc_d    = rc_q;
      win_d   = win_q;
      slot_d  = slot_q;
      sin_d   = sin_q;
      sub_d   = sub_q;
      pass_d  = pass_q;
      iss_d   = iss_q;
      ld_d    = ld_q;
      rk_d    = rk_q;
      vld_d   = 1'b0;
      rnd_d   = rnd_q;
      busy_d  = busy_q;
      done_d  = done_q;
      sb_go   = 1'b0;
      bi      = '0;
      rnd_n   = wi_q[5:2] - 4'd1;
      rcw     = '0;
      rcw[0]  = {input_transform(le_of(rc_q), bus.L), {D{1'b0}}};
      nw      = win_q[NK-1] ^ win_q[0];
      for (int l = 0; l < N_SBOX; l++) begin
         bi       = 2'(int'(pass_q) * N_SBOX + l);
         sb_in[l] = sin_q[bi];
      end
      unique case (state_q)
         S_IDLE: begin
            if (bus.req && ld_q && !done_q && !busy_q) begin
               busy_d  = 1'b1;
               state_d = S_SEL;
            end else begin
               busy_d = 1'b0;
            end
         end
         S_SEL: begin
            pass_d = '0;
            iss_d  = 1'b0;
            sin_d  = win_q[NK-1];
            if (wi_q < 6'(NK)) begin
               kind_d  = K_KEY;
               state_d = S_XOR;
            end else if (mod_q == 3'd0) begin
               kind_d  = K_ROT;
               sin_d   = {win_q[NK-1][0], win_q[NK-1][3], win_q[NK-1][2], win_q[NK-1][1]};
               state_d = S_SUB;
            end else if (NK == 8 && mod_q == 3'd4) begin
               kind_d  = K_SUB;
               state_d = S_SUB;
            end else begin
               kind_d  = K_LIN;
               state_d = S_XOR;
            end
         end
         S_SUB: begin
            if (!iss_q) begin
               sb_go = 1'b1;
               iss_d = 1'b1;
            end else if (&rdy_q) begin
               for (int l = 0; l < N_SBOX; l++) begin
                  bi        = 2'(int'(pass_q) * N_SBOX + l);
                  sub_d[bi] = sbo_q[l];
               end
               iss_d = 1'b0;
               if (pass_q == 2'(NP - 1)) state_d = S_XOR;
               else pass_d = pass_q + 2'd1;
            end
         end
         S_XOR: begin
            unique case (kind_q)
               K_KEY:   nw = win_q[0];
               K_ROT:   nw = sub_q ^ rcw ^ win_q[0];
               K_SUB:   nw = sub_q ^ win_q[0];
               default: nw = win_q[NK-1] ^ win_q[0];
            endcase
            for (int j = 0; j < NK - 1; j++) win_d[j] = win_q[j+1];
            win_d[NK-1]         = nw;
            slot_d[wi_q[1:0]]   = nw;
            wi_d                = wi_q + 6'd1;
            mod_d               = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
            if (kind_q == K_ROT)
               rc_d = {1'b0, rc_q[0:6]} ^ ({8{rc_q[7]}} & bus.P);
            state_d = (wi_q[1:0] == 2'd3) ? S_EMIT : S_SEL;
         end
         S_EMIT: begin
            for (int rr = 0; rr < 4; rr++)
               for (int cc = 0; cc < 4; cc++)
                  rk_d[rr][cc] = slot_q[cc][rr];
            vld_d   = 1'b1;
            rnd_d   = rnd_n;
            done_d  = (rnd_n == 4'(NR));
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.start) begin
         state_d = S_IDLE;
         win_d   = bus.key_in;
         wi_d    = '0;
         mod_d   = '0;
         rc_d    = 8'd128;
         rnd_d   = '0;
         done_d  = 1'b0;
         busy_d  = 1'b0;
         vld_d   = 1'b0;
         iss_d   = 1'b0;
         ld_d    = 1'b1;
         sb_go   = 1'b0;
      end
   end

   assign bus.rk_o   = rk_q;
   assign bus.rk_vld = vld_q;
   assign bus.rnd_o  = rnd_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_clm_key_schedule_nk.sv
// Directed bench: FIPS-197 key expansions for NK=4/6/8, a 1-lane S-box variant
// with random redundancy masks, restart via start, and reset behaviour.
module tb_clm_key_schedule_nk;
   localparam int D  = 4;
   localparam int BW = 8 + D;

   localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R4_1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R4_2   = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] R4_10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [127:0] R6_1   = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
   localparam logic [127:0] R6_2   = 128'hec12068e6c827f6b0e7a95b95c56fec2;
   localparam logic [127:0] R6_12  = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] R8_2   = 128'h9ba354118e6925afa51a8b5f2067fcde;
   localparam logic [127:0] R8_3   = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
   localparam logic [127:0] R8_14  = 128'hfe4890d1e6188d0b046df344706c631e;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   clm_key_schedule_nk_if #(.D(D), .NK(4), .N_SBOX(4), .R_W(8)) if4 ();
   clm_key_schedule_nk_if #(.D(D), .NK(4), .N_SBOX(1), .R_W(8)) ifs ();
   clm_key_schedule_nk_if #(.D(D), .NK(6), .N_SBOX(2), .R_W(8)) if6 ();
   clm_key_schedule_nk_if #(.D(D), .NK(8), .N_SBOX(4), .R_W(8)) if8 ();

   clm_key_schedule_nk #(.D(D), .NK(4), .N_SBOX(4), .R_W(8)) u4  (.clk(clk), .rst(rst), .bus(if4));
   clm_key_schedule_nk #(.D(D), .NK(4), .N_SBOX(1), .R_W(8)) u4s (.clk(clk), .rst(rst), .bus(ifs));
   clm_key_schedule_nk #(.D(D), .NK(6), .N_SBOX(2), .R_W(8)) u6  (.clk(clk), .rst(rst), .bus(if6));
   clm_key_schedule_nk #(.D(D), .NK(8), .N_SBOX(4), .R_W(8)) u8  (.clk(clk), .rst(rst), .bus(if8));

   logic req_v   [4];
   logic start_v [4];
   logic vld_v   [4];
   assign if4.req = req_v[0];   assign if4.start = start_v[0];   assign vld_v[0] = if4.rk_vld;
   assign ifs.req = req_v[1];   assign ifs.start = start_v[1];   assign vld_v[1] = ifs.rk_vld;
   assign if6.req = req_v[2];   assign if6.start = start_v[2];   assign vld_v[2] = if6.rk_vld;
   assign if8.req = req_v[3];   assign if8.start = start_v[3];   assign vld_v[3] = if8.rk_vld;

   int nvec = 0;
   int nerr = 0;
   logic [127:0] cap [4][16];
   int cnt [4] = '{0, 0, 0, 0};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] deemb(input logic [3:0][3:0][BW-1:0] k);
      logic [127:0] v;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            v[127 - 32*c - 8*r -: 8] = k[r][c][BW-1:D];
      return v;
   endfunction

   function automatic logic [7:0][3:0][BW-1:0] emb(input logic [255:0] h);
      logic [7:0][3:0][BW-1:0] e;
      for (int i = 0; i < 8; i++)
         for (int b = 0; b < 4; b++)
            e[i][b] = {h[255 - 32*i - 8*b -: 8], {D{1'b0}}};
      return e;
   endfunction

   task automatic pulse_req(input int idx);
      @(negedge clk); req_v[idx] = 1'b1;
      @(negedge clk); req_v[idx] = 1'b0;
   endtask

   task automatic wait_vld(input int idx);
      int t;
      t = 0;
      while (!vld_v[idx] && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("vld_timeout", 128'(t < 400), 128'd1);
   endtask

   task automatic run_rounds(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         pulse_req(idx);
         wait_vld(idx);
      end
   endtask

   // record every emitted round key by its round index
   always @(negedge clk) begin
      if (if4.rk_vld) begin cap[0][if4.rnd_o] <= deemb(if4.rk_o); cnt[0] <= cnt[0] + 1; end
      if (ifs.rk_vld) begin cap[1][ifs.rnd_o] <= deemb(ifs.rk_o); cnt[1] <= cnt[1] + 1; end
      if (if6.rk_vld) begin cap[2][if6.rnd_o] <= deemb(if6.rk_o); cnt[2] <= cnt[2] + 1; end
      if (if8.rk_vld) begin cap[3][if8.rnd_o] <= deemb(if8.rk_o); cnt[3] <= cnt[3] + 1; end
      ifs.r = 8'($urandom);
   end

   initial begin
      logic [7:0][3:0][BW-1:0] kt;
      logic [7:0][7:0] lid;
      int c;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin req_v[i] = 1'b0; start_v[i] = 1'b0; end
      for (int i = 0; i < 8; i++) lid[i] = 8'(1) << i;
      if4.L = lid; ifs.L = lid; if6.L = lid; if8.L = lid;
      if4.P = 8'hD8; ifs.P = 8'hD8; if6.P = 8'hD8; if8.P = 8'hD8;
      if4.r = '0; if6.r = '0; if8.r = '0;
      kt = emb({K128, 128'h0}); if4.key_in = kt[3:0]; ifs.key_in = kt[3:0];
      kt = emb({K192, 64'h0});  if6.key_in = kt[5:0];
      kt = emb(K256);           if8.key_in = kt;

      repeat (3) @(negedge clk);
      chk("rst_rk", deemb(if4.rk_o), '0);
      chk("rst_ctl", 128'({if4.rk_vld, if4.rnd_o, if4.busy, if4.done}), '0);
      rst = 1'b0;

      pulse_req(0);
      repeat (30) @(negedge clk);
      chk("no_vld_unloaded", 128'(cnt[0]), 128'd0);

      @(negedge clk);
      for (int i = 0; i < 4; i++) start_v[i] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

      fork
         run_rounds(0, 11);
         run_rounds(1, 11);
         run_rounds(2, 13);
         run_rounds(3, 15);
      join
      @(negedge clk);

      chk("nk4_rnd0", cap[0][0], K128);
      chk("nk4_rnd1", cap[0][1], R4_1);
      chk("nk4_rnd2", cap[0][2], R4_2);
      chk("nk4_rnd10", cap[0][10], R4_10);
      chk("nk4_cnt", 128'(cnt[0]), 128'd11);
      chk("nk4_done", 128'(if4.done), 128'd1);
      chk("ns1_rnd1", cap[1][1], R4_1);
      chk("ns1_rnd10", cap[1][10], R4_10);
      chk("ns1_done", 128'(ifs.done), 128'd1);
      chk("nk6_rnd0", cap[2][0], K192[191:64]);
      chk("nk6_rnd1", cap[2][1], R6_1);
      chk("nk6_rnd2", cap[2][2], R6_2);
      chk("nk6_rnd12", cap[2][12], R6_12);
      chk("nk6_cnt", 128'(cnt[2]), 128'd13);
      chk("nk6_done", 128'(if6.done), 128'd1);
      chk("nk8_rnd1", cap[3][1], K256[127:0]);
      chk("nk8_rnd2", cap[3][2], R8_2);
      chk("nk8_rnd3", cap[3][3], R8_3);
      chk("nk8_rnd14", cap[3][14], R8_14);
      chk("nk8_done", 128'(if8.done), 128'd1);

      c = cnt[0];
      pulse_req(0);
      repeat (30) @(negedge clk);
      chk("req_after_done", 128'(cnt[0] - c), 128'd0);

      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      chk("restart_ctl", 128'({if4.rk_vld, if4.rnd_o, if4.busy, if4.done}), '0);
      c = cnt[0];
      pulse_req(0);
      pulse_req(0);
      wait_vld(0);
      req_v[0] = 1'b1;
      @(negedge clk); req_v[0] = 1'b0;
      repeat (30) @(negedge clk);
      chk("busy_req_ignored", 128'(cnt[0] - c), 128'd1);
      chk("restart_rnd0", cap[0][0], K128);
      run_rounds(0, 4);
      pulse_req(0);
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      chk("abort_ctl", 128'({if4.rk_vld, if4.rnd_o, if4.busy, if4.done}), 128'({1'b0, 4'd0, 1'b0, 1'b0}));
      c = cnt[0];
      run_rounds(0, 11);
      @(negedge clk);
      chk("abort_cnt", 128'(cnt[0] - c), 128'd11);
      chk("abort_rnd1", cap[0][1], R4_1);
      chk("abort_rnd10", cap[0][10], R4_10);
      chk("abort_done", 128'(if4.done), 128'd1);

      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      pulse_req(0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rk", deemb(if4.rk_o), '0);
      chk("midrst_ctl", 128'({if4.rk_vld, if4.rnd_o, if4.busy, if4.done}), '0);
      rst = 1'b0;
      c = cnt[0];
      pulse_req(0);
      repeat (40) @(negedge clk);
      chk("midrst_no_vld", 128'(cnt[0] - c), 128'd0);
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      run_rounds(0, 2);
      @(negedge clk);
      chk("midrst_cnt", 128'(cnt[0] - c), 128'd2);
      chk("midrst_rnd1", cap[0][1], R4_1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
